muldiv_seq: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/div_step.sv | 24 ++
 rtl/muldiv_seq.sv | 160 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: mult/div sequencer state encoding and op codes.
// ctrl_unit and muldiv_seq both import this package.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MULT = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem < divisor <= 2^(WIDTH-1) keeps shifted below 2^WIDTH, so bit WIDTH of diff is a clean borrow.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = ~diff[WIDTH];
  assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle signed MULT (radix-2 Booth) / DIV (restoring) sequencer feeding the
// HI/LO register pair, driven by ctrl_unit over a start/busy/done handshake.
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_w,
  output logic             lo_w,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2:0]         state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic               op_q;
  logic               neg_q;
  logic               neg_r;
  logic               dz;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // acc = {hi, lo, booth_q-1}; the division path reuses hi as remainder and lo as quotient.
  assign acc_hi = acc[2*WIDTH:WIDTH+1];
  assign acc_lo = acc[WIDTH:1];

  assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

  // Booth add is one bit wider so a most-negative multiplicand cannot overflow before the shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    booth_sum = {acc_hi[WIDTH-1], acc_hi};
    case (acc[1:0])
      2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
    endcase
    booth_next = {booth_sum, acc_lo};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (mcand),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic. A zero divisor skips the iterations but still passes through FIX,
  // giving a fixed two-edge latency to the completion pulse.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_DIV && b_in == '0) state_next = ST_FIX;
          else if (op == OP_DIV)          state_next = ST_DIV;
          else                            state_next = ST_MULT;
        end
      end
      ST_MULT: if (cnt == '0) state_next = ST_FIX;
      ST_DIV:  if (cnt == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    div_zero = (state == ST_DONE) && dz;
    hi_w     = (state == ST_DONE) && !dz;
    lo_w     = (state == ST_DONE) && !dz;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every datapath register is reset, since an abandoned operation must leave HI/LO cleared.
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      op_q   <= OP_MULT;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= CNT_W'(WIDTH - 1);
            dz   <= (op == OP_DIV) && (b_in == '0);
            if (op == OP_MULT) begin
              acc   <= {{WIDTH{1'b0}}, b_in, 1'b0};
              mcand <= a_in;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a_mag, 1'b0};
              mcand <= b_mag;
              neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r <= a_in[WIDTH-1];
            end
          end
        end
        ST_MULT: begin
          acc <= booth_next;
          cnt <= cnt - 1'b1;
        end
        ST_DIV: begin
          acc <= {rem_next, quo_next, 1'b0};
          cnt <= cnt - 1'b1;
        end
        ST_FIX: begin
          if (!dz) begin
            if (op_q == OP_MULT) begin
              hi_out <= acc_hi;
              lo_out <= acc_lo;
            end else begin
              hi_out <= neg_r ? (~acc_hi + 1'b1) : acc_hi;
              lo_out <= neg_q ? (~acc_lo + 1'b1) : acc_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signs, divide-by-zero, corners,
// start-while-busy, and asynchronous reset mid-operation.
module tb_muldiv_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = OP_MULT;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div_zero, hi_w, lo_w;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_pass   = 0;

  int          r_first;
  int          r_ndone;
  logic        r_dz;
  logic        r_w;
  logic        r_busy1;
  logic        r_busy_done;
  logic [31:0] r_hi, r_lo;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_w     (hi_w),
    .lo_w     (lo_w),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Starts one operation in cycle 0, scrambles the operand inputs after accept, optionally
  // pulses a second start at cycle pulse_at, and records completion behaviour over ncyc cycles.
  task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input logic [31:0] a2, input logic [31:0] b2,
                        input int ncyc);
    @(posedge clk); #1;
    start = 1'b1; op = op_i; a_in = a; b_in = b;
    r_first = -1; r_ndone = 0; r_dz = 1'b0; r_w = 1'b0;
    r_busy1 = 1'b0; r_busy_done = 1'b0; r_hi = '0; r_lo = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = 1'b0; op = ~op_i; a_in = ~a; b_in = ~b;
      if (k == pulse_at) begin
        start = 1'b1; op = OP_MULT; a_in = a2; b_in = b2;
      end
      @(negedge clk);
      if (k == 1) r_busy1 = busy;
      if (done) begin
        r_ndone++;
        if (r_first < 0) begin
          r_first = k;
          r_dz = div_zero;
          r_w = hi_w | lo_w;
          r_busy_done = busy;
          r_hi = hi_out;
          r_lo = lo_out;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int n_rst_done;

    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 7 * -3
    run_op(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 0, '0, '0, 40);
    check("mul7x-3 busy c1", {31'd0, r_busy1}, 32'd1);
    check("mul7x-3 done cycle", r_first, 34);
    check("mul7x-3 done count", r_ndone, 1);
    check("mul7x-3 strobes", {31'd0, r_w}, 32'd1);
    check("mul7x-3 busy at done", {31'd0, r_busy_done}, 32'd1);
    check("mul7x-3 hi", r_hi, 32'hFFFF_FFFF);
    check("mul7x-3 lo", r_lo, 32'hFFFF_FFEB);

    // -7 / 2
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, '0, '0, 40);
    check("div-7/2 done cycle", r_first, 34);
    check("div-7/2 lo", r_lo, 32'hFFFF_FFFD);
    check("div-7/2 hi", r_hi, 32'hFFFF_FFFF);

    // -7 / -2
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, '0, '0, 40);
    check("div-7/-2 lo", r_lo, 32'h0000_0003);
    check("div-7/-2 hi", r_hi, 32'hFFFF_FFFF);

    // Preload HI/LO: 0x66666666 * 0x2AAAAAAB = 0x11111111_22222222
    run_op(OP_MULT, 32'h6666_6666, 32'h2AAA_AAAB, 0, '0, '0, 40);
    check("preload hi", r_hi, 32'h1111_1111);
    check("preload lo", r_lo, 32'h2222_2222);

    // 5 / 0
    run_op(OP_DIV, 32'h0000_0005, 32'h0000_0000, 0, '0, '0, 6);
    check("div0 done cycle", r_first, 2);
    check("div0 done count", r_ndone, 1);
    check("div0 flag", {31'd0, r_dz}, 32'd1);
    check("div0 strobes", {31'd0, r_w}, 32'd0);
    check("div0 hi held", r_hi, 32'h1111_1111);
    check("div0 lo held", r_lo, 32'h2222_2222);

    // Corners
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, '0, '0, 40);
    check("minxmin hi", r_hi, 32'h4000_0000);
    check("minxmin lo", r_lo, 32'h0000_0000);
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0, '0, '0, 40);
    check("maxxmin hi", r_hi, 32'hC000_0000);
    check("maxxmin lo", r_lo, 32'h8000_0000);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0, 40);
    check("-1x-1 hi", r_hi, 32'h0000_0000);
    check("-1x-1 lo", r_lo, 32'h0000_0001);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, '0, 40);
    check("min/-1 lo", r_lo, 32'h8000_0000);
    check("min/-1 hi", r_hi, 32'h0000_0000);

    // Start while busy: 9*9 pulsed at cycle 10 is dropped
    run_op(OP_MULT, 32'd3, 32'd4, 10, 32'd9, 32'd9, 40);
    check("busy-start done cycle", r_first, 34);
    check("busy-start done count", r_ndone, 1);
    check("busy-start lo", r_lo, 32'd12);
    check("busy-start hi", r_hi, 32'd0);

    // 7 / -2, with a start pulse in the DONE cycle that must be ignored
    run_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 34, 32'd9, 32'd9, 40);
    check("div7/-2 done count", r_ndone, 1);
    check("div7/-2 lo", r_lo, 32'hFFFF_FFFD);
    check("div7/-2 hi", r_hi, 32'h0000_0001);

    // Asynchronous reset in cycle 15 of a DIV
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; a_in = 32'd1000; b_in = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi_out, 32'd0);
    check("rst lo", lo_out, 32'd0);
    n_rst_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) n_rst_done++;
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_rst_done++;
    end
    check("rst no done", n_rst_done, 0);

    run_op(OP_DIV, 32'd100, 32'd7, 0, '0, '0, 40);
    check("div100/7 done cycle", r_first, 34);
    check("div100/7 lo", r_lo, 32'd14);
    check("div100/7 hi", r_hi, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
